// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller: FSM state encoding,
// status codes reported to the host, and helpers that map a state onto the
// host-visible done/status outputs.
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      HOLD    = 3'd2,
      RUN     = 3'd3,
      HALT    = 3'd4,
      TIMEOUT = 3'd5,
      ERROR   = 3'd6
   } state_e;

   localparam logic [1:0] STAT_NONE    = 2'd0;
   localparam logic [1:0] STAT_HALT    = 2'd1;
   localparam logic [1:0] STAT_TIMEOUT = 2'd2;
   localparam logic [1:0] STAT_ERR     = 2'd3;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned HOLD_W = 4;

   // A run has finished once the FSM sits in one of the three terminal states.
   function automatic logic is_done_state(input state_e s);
      return (s == HALT) || (s == TIMEOUT) || (s == ERROR);
   endfunction

   // Status code reported while a terminal state is held; zero otherwise.
   function automatic logic [1:0] status_of(input state_e s);
      logic [1:0] code;
      case (s)
         HALT:    code = STAT_HALT;
         TIMEOUT: code = STAT_TIMEOUT;
         ERROR:   code = STAT_ERR;
         default: code = STAT_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/run_ctrl_wdog.sv
// RUN-cycle counter with timeout compare. The count is cleared on request,
// advances by one on each enabled cycle and saturates instead of wrapping.
// expired flags the last permitted RUN cycle (count == TIMEOUT_CYCLES-1).
module run_ctrl_wdog
   import run_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 10000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             expired
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = '1;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear wins over enable; hold at all-ones rather than wrap.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != MAX_CNT)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count   = count_q;
   assign expired = (count_q == LAST_CNT);

endmodule

// File: rtl/run_ctrl.sv
// Run controller: accepts an instruction image over a valid/ready stream,
// writes it into instruction memory, holds the core in reset for a fixed
// number of cycles, releases it, and reports how the run ended (halt,
// timeout or error) until the host clears the result.
//
// Handshake: a word is transferred on a rising clk edge where
// load_valid && load_ready; load_ready is high only in IDLE and LOAD and
// does not depend on load_valid in the same cycle.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 10000,
   parameter int unsigned HOLD_CYCLES    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              start,
   input  logic              clear,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              core_rst,
   input  logic              halt_idif_p1,
   input  logic              err_p1,
   output logic [CNT_W-1:0]  inst_count,
   output logic              done,
   output logic [1:0]        status,
   output state_e            dbg_state
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   state_e            state_q;
   state_e            state_d;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic [HOLD_W-1:0] hold_cnt_d;

   logic              load_ready_q;
   logic              imem_we_q;
   logic [ADDR_W-1:0] imem_addr_q;
   logic [DATA_W-1:0] imem_wdata_q;
   logic              core_rst_q;
   logic              done_q;
   logic [1:0]        status_q;

   logic              xfer;
   logic              wd_clr;
   logic              wd_en;
   logic              wd_expired;
   logic [CNT_W-1:0]  wd_count;

   // load_ready_q mirrors "state is IDLE or LOAD", so this is the handshake.
   assign xfer = load_valid && load_ready_q;

   run_ctrl_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (wd_clr),
      .en     (wd_en),
      .count  (wd_count),
      .expired(wd_expired)
   );

   // Next-state logic, HOLD timer and watchdog control.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      wd_clr     = 1'b0;
      wd_en      = 1'b0;
      case (state_q)
         IDLE: begin
            // A transfer takes precedence over start in the same cycle.
            if (xfer) begin
               state_d = load_last ? HOLD : LOAD;
            end else if (start) begin
               state_d = HOLD;
            end
         end
         LOAD: begin
            if (xfer && load_last) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         RUN: begin
            // The exit cycle does not count, so the count freezes on leaving.
            if (err_p1) begin
               state_d = ERROR;
            end else if (halt_idif_p1) begin
               state_d = HALT;
            end else if (wd_expired) begin
               state_d = TIMEOUT;
            end else begin
               wd_en = 1'b1;
            end
         end
         HALT, TIMEOUT, ERROR: begin
            if (clear) begin
               state_d = IDLE;
               wd_clr  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Every entry into HOLD restarts the hold timer and the run count.
      if ((state_d == HOLD) && (state_q != HOLD)) begin
         hold_cnt_d = '0;
         wd_clr     = 1'b1;
      end
   end

   // State and hold timer registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // Registered outputs, decoded from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (!rst) begin
         load_ready_q <= 1'b1;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         core_rst_q   <= 1'b1;
         done_q       <= 1'b0;
         status_q     <= STAT_NONE;
      end else begin
         load_ready_q <= (state_d == IDLE) || (state_d == LOAD);
         imem_we_q    <= xfer;
         if (xfer) begin
            imem_addr_q  <= load_addr;
            imem_wdata_q <= load_data;
         end
         core_rst_q <= (state_d != RUN);
         done_q     <= is_done_state(state_d);
         status_q   <= status_of(state_d);
      end
   end

   assign load_ready = load_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign core_rst   = core_rst_q;
   assign inst_count = wd_count;
   assign done       = done_q;
   assign status     = status_q;
   assign dbg_state  = state_q;

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 10000: maximum RUN cycles; legal range 1..65535.
REQ-002 Parameter HOLD_CYCLES, default 3: core reset hold length in cycles; legal range 1..15.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 load_valid  in  1  image word offered.
REQ-006 load_ready  out  1  loader accepts word.
REQ-007 load_addr  in  16  imem word address.
REQ-008 load_data  in  16  instruction word.
REQ-009 load_last  in  1  final word of image.
REQ-010 start  in  1  run preloaded image without loading.
REQ-011 clear  in  1  return from a done state to IDLE.
REQ-012 imem_we / imem_addr[15:0] / imem_wdata[15:0]  out  imem write port.
REQ-013 core_rst  out  1  active-high reset to core.
REQ-014 halt_idif_p1  in  1  core halt indication.
REQ-015 err_p1  in  1  core error indication.
REQ-016 inst_count  out  16  RUN cycles counted.
REQ-017 done  out  1  run finished.
REQ-018 status  out  2  0 none, 1 halt, 2 timeout, 3 error.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, HOLD, RUN, HALT, TIMEOUT, ERROR.
REQ-020 load_ready SHALL be 1 only in IDLE and LOAD; a transfer occurs when load_valid && load_ready.
REQ-021 Each transfer SHALL drive imem_we=1 with imem_addr/imem_wdata registered one cycle after the transfer; imem_we=0 otherwise.
REQ-022 IDLE: a transfer without load_last -> LOAD; a transfer with load_last -> HOLD; start without a transfer -> HOLD.
REQ-023 IDLE: start and a transfer in the same cycle -> the transfer wins and start is ignored.
REQ-024 LOAD: a transfer with load_last -> HOLD; start is ignored.
REQ-025 HOLD SHALL last exactly HOLD_CYCLES cycles, then -> RUN.
REQ-026 core_rst SHALL be 1 in every state except RUN.
REQ-027 Entering HOLD SHALL zero inst_count.
REQ-028 RUN: inst_count SHALL increment once per RUN cycle.
REQ-029 RUN exit priority, evaluated each cycle: err_p1 -> ERROR; else halt_idif_p1 -> HALT; else inst_count == TIMEOUT_CYCLES-1 -> TIMEOUT.
REQ-030 inst_count SHALL freeze on leaving RUN and never wrap.
REQ-031 done SHALL be 1 in HALT, TIMEOUT and ERROR; status SHALL hold the matching code while done=1, else 0.
REQ-032 halt_idif_p1 and err_p1 SHALL be ignored outside RUN.
REQ-033 In a done state, clear -> IDLE with inst_count=0; other inputs are ignored.
REQ-034 clear SHALL be ignored outside the done states.

Reset
REQ-035 rst=0 at a clk edge SHALL force IDLE, load_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, inst_count=0, done=0, status=0, HOLD counter=0, from any state including mid-LOAD and mid-RUN.

Structure
REQ-036 Package run_ctrl_pkg SHALL hold the state enum and the status code constants (STAT_NONE, STAT_HALT, STAT_TIMEOUT, STAT_ERR).
REQ-037 Sub-module run_ctrl_wdog SHALL implement the RUN counter and timeout compare (inputs clr, en; outputs count, expired).
REQ-038 All outputs SHALL be registered.

Verification
REQ-039 Load 4 words (addrs 0..3, data 16'hA000..A003), last on the 4th -> 4 imem_we pulses with matching addr/data, core_rst=1 for exactly 3 cycles, then RUN.
REQ-040 start in IDLE, halt_idif_p1 after 57 RUN cycles -> status=1, done=1, inst_count=57, core_rst=1.
REQ-041 TIMEOUT_CYCLES=20, no halt -> status=2 after 20 RUN cycles, inst_count=19.
REQ-042 err_p1 and halt_idif_p1 together in RUN -> status=3; subsequent clear -> IDLE, inst_count=0.
REQ-043 start and load_valid together in IDLE -> word written, state LOAD, HOLD not entered.
REQ-044 rst=0 asserted mid-RUN at inst_count=30 -> next cycle IDLE, core_rst=1, inst_count=0, done=0.
